// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute and drives datapath selects, loads and strobes.
// Memory waits are bounded by MEM_TIMEOUT; illegal, misaligned or timed-out operations park it in a sticky TRAP.
module mc_control_fsm #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_TIMEOUT = 64,
  parameter int EN_MDU      = 1,
  localparam int BYTES = DATA_WIDTH / 8,
  localparam int OFFW  = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [6:0]       opcode_i,
  input  logic [2:0]       funct3_i,
  input  logic [6:0]       funct7_i,
  input  logic             br_en_i,
  input  logic [OFFW-1:0]  addr_lsb_i,
  input  logic             mem_resp_i,
  input  logic             mdu_done_i,
  output logic [1:0]       pcmux_sel_o,
  output logic             alumux1_sel_o,
  output logic [2:0]       alumux2_sel_o,
  output logic [3:0]       regfilemux_sel_o,
  output logic             marmux_sel_o,
  output logic             cmpmux_sel_o,
  output logic [2:0]       aluop_o,
  output logic [2:0]       cmpop_o,
  output logic             load_pc_o,
  output logic             load_ir_o,
  output logic             load_regfile_o,
  output logic             load_mar_o,
  output logic             load_mdr_o,
  output logic             load_data_out_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic [BYTES-1:0] mem_byte_enable_o,
  output logic [OFFW-1:0]  byte_offset_o,
  output logic             mdu_start_o,
  output logic             mdu_wb_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [1:0] PCMUX_PC4 = 2'd0, PCMUX_ALU = 2'd1, PCMUX_MOD2 = 2'd2;
  localparam logic       ALUMUX1_RS1 = 1'b0, ALUMUX1_PC = 1'b1;
  localparam logic [2:0] ALUMUX2_I = 3'd0, ALUMUX2_U = 3'd1, ALUMUX2_B = 3'd2;
  localparam logic [2:0] ALUMUX2_S = 3'd3, ALUMUX2_J = 3'd4, ALUMUX2_RS2 = 3'd5;
  localparam logic [3:0] RF_ALU = 4'd0, RF_BR_EN = 4'd1, RF_U_IMM = 4'd2, RF_LW = 4'd3;
  localparam logic [3:0] RF_PC4 = 4'd4, RF_LB = 4'd5, RF_LBU = 4'd6, RF_LH = 4'd7, RF_LHU = 4'd8;
  localparam logic       MARMUX_PC = 1'b0, MARMUX_ALU = 1'b1;
  localparam logic       CMPMUX_RS2 = 1'b0, CMPMUX_I = 1'b1;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SRA = 3'd2, ALU_SUB = 3'd3;
  localparam logic [2:0] CMP_BLT = 3'b100, CMP_BLTU = 3'b110;
  localparam logic [2:0] F3_ADD = 3'b000, F3_SLT = 3'b010, F3_SLTU = 3'b011, F3_SR = 3'b101;

  localparam logic [1:0] CAUSE_ILL = 2'd0, CAUSE_MIS_LD = 2'd1, CAUSE_MIS_ST = 2'd2, CAUSE_TMO = 2'd3;

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [4:0] {
    FETCH1, FETCH2, FETCH3, DECODE, IMM, REGREG, MDU_WAIT, LUI, AUIPC,
    BR, JAL, JALR, CALC_ADDR, LD1, LD2, ST1, ST2, TRAP
  } state_t;

  state_t          state_q;
  logic [OFFW-1:0] byte_offset_q;
  logic [CW-1:0]   tmo_cnt_q;
  logic            mdu_busy_q;
  logic            trap_q;
  logic [1:0]      trap_cause_q;

  logic            is_store, is_mul, misaligned, tmo_hit, dec_illegal, enter_trap;
  logic [1:0]      trap_cause_d;
  state_t          wait_exit;
  logic [BYTES-1:0] st_mask;

  assign is_store   = (opcode_i == OP_STORE);
  assign is_mul     = (funct7_i == 7'b0000001);
  assign misaligned = ((funct3_i[1:0] == 2'b10) && (addr_lsb_i != '0)) ||
                      ((funct3_i[1:0] == 2'b01) && addr_lsb_i[0]);
  // Only counts while no response has arrived, so a late mem_resp still wins.
  assign tmo_hit    = (MEM_TIMEOUT != 0) && !mem_resp_i && (tmo_cnt_q == TO_LAST);

  always_comb begin
    dec_illegal = 1'b0;
    case (opcode_i)
      OP_REG:   dec_illegal = is_mul && (EN_MDU == 0);
      OP_BR:    dec_illegal = (funct3_i[2:1] == 2'b01);
      OP_LOAD:  dec_illegal = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
      OP_STORE: dec_illegal = funct3_i[2] || (funct3_i[1:0] == 2'b11);
      OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: dec_illegal = 1'b0;
      default:  dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    enter_trap   = 1'b0;
    trap_cause_d = CAUSE_ILL;
    wait_exit    = FETCH3;
    case (state_q)
      DECODE:    enter_trap = dec_illegal;
      CALC_ADDR: begin
        enter_trap   = misaligned;
        trap_cause_d = is_store ? CAUSE_MIS_ST : CAUSE_MIS_LD;
      end
      FETCH2, LD1, ST1: begin
        enter_trap   = tmo_hit;
        trap_cause_d = CAUSE_TMO;
        wait_exit    = (state_q == LD1) ? LD2 : (state_q == ST1) ? ST2 : FETCH3;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= FETCH1;
      byte_offset_q <= '0;
      tmo_cnt_q     <= '0;
      mdu_busy_q    <= 1'b0;
      trap_q        <= 1'b0;
      trap_cause_q  <= CAUSE_ILL;
    end else begin
      tmo_cnt_q  <= '0;
      mdu_busy_q <= 1'b0;
      if (state_q == CALC_ADDR) byte_offset_q <= addr_lsb_i;
      if (enter_trap) begin
        state_q      <= TRAP;
        trap_q       <= 1'b1;
        trap_cause_q <= trap_cause_d;
      end else begin
        case (state_q)
          FETCH1: state_q <= FETCH2;
          FETCH2, LD1, ST1: begin
            if (mem_resp_i) state_q <= wait_exit;
            else            tmo_cnt_q <= tmo_cnt_q + CW'(1);
          end
          FETCH3: state_q <= DECODE;
          DECODE: begin
            case (opcode_i)
              OP_IMM:             state_q <= IMM;
              OP_REG:             state_q <= is_mul ? MDU_WAIT : REGREG;
              OP_LUI:             state_q <= LUI;
              OP_AUIPC:           state_q <= AUIPC;
              OP_BR:              state_q <= BR;
              OP_JAL:             state_q <= JAL;
              OP_JALR:            state_q <= JALR;
              OP_LOAD, OP_STORE:  state_q <= CALC_ADDR;
              default:            state_q <= TRAP;
            endcase
          end
          CALC_ADDR: state_q <= is_store ? ST1 : LD1;
          MDU_WAIT: begin
            if (mdu_done_i) state_q <= FETCH1;
            else            mdu_busy_q <= 1'b1;
          end
          TRAP:    state_q <= TRAP;
          default: state_q <= FETCH1;
        endcase
      end
    end
  end

  always_comb begin
    case (funct3_i[1:0])
      2'b00:   st_mask = BYTES'(1);
      2'b01:   st_mask = BYTES'(3);
      default: st_mask = '1;
    endcase
  end

  // Controls are gated by rst_ni so strobes and loads drop the moment reset asserts.
  always_comb begin
    pcmux_sel_o       = PCMUX_PC4;
    alumux1_sel_o     = ALUMUX1_RS1;
    alumux2_sel_o     = ALUMUX2_I;
    regfilemux_sel_o  = RF_ALU;
    marmux_sel_o      = MARMUX_PC;
    cmpmux_sel_o      = CMPMUX_RS2;
    aluop_o           = funct3_i;
    cmpop_o           = funct3_i;
    load_pc_o         = 1'b0;
    load_ir_o         = 1'b0;
    load_regfile_o    = 1'b0;
    load_mar_o        = 1'b0;
    load_mdr_o        = 1'b0;
    load_data_out_o   = 1'b0;
    mem_read_o        = 1'b0;
    mem_write_o       = 1'b0;
    mdu_start_o       = 1'b0;
    mdu_wb_o          = 1'b0;
    mem_byte_enable_o = '1;
    if (rst_ni) begin
      case (state_q)
        FETCH1: load_mar_o = 1'b1;
        FETCH2: begin
          load_mdr_o = 1'b1;
          mem_read_o = 1'b1;
        end
        FETCH3: load_ir_o = 1'b1;
        IMM: begin
          load_regfile_o = 1'b1;
          load_pc_o      = 1'b1;
          if (funct3_i == F3_SLT || funct3_i == F3_SLTU) begin
            cmpop_o          = (funct3_i == F3_SLT) ? CMP_BLT : CMP_BLTU;
            regfilemux_sel_o = RF_BR_EN;
            cmpmux_sel_o     = CMPMUX_I;
          end else if (funct3_i == F3_SR && funct7_i[5]) begin
            aluop_o = ALU_SRA;
          end
        end
        REGREG: begin
          load_regfile_o = 1'b1;
          load_pc_o      = 1'b1;
          alumux2_sel_o  = ALUMUX2_RS2;
          if (funct3_i == F3_SLT || funct3_i == F3_SLTU) begin
            cmpop_o          = (funct3_i == F3_SLT) ? CMP_BLT : CMP_BLTU;
            regfilemux_sel_o = RF_BR_EN;
          end else if (funct3_i == F3_ADD && funct7_i[5]) begin
            aluop_o = ALU_SUB;
          end else if (funct3_i == F3_SR && funct7_i[5]) begin
            aluop_o = ALU_SRA;
          end
        end
        MDU_WAIT: begin
          mdu_start_o    = !mdu_busy_q;
          load_regfile_o = mdu_done_i;
          load_pc_o      = mdu_done_i;
          mdu_wb_o       = mdu_done_i;
        end
        LUI: begin
          load_regfile_o   = 1'b1;
          load_pc_o        = 1'b1;
          regfilemux_sel_o = RF_U_IMM;
        end
        AUIPC: begin
          load_regfile_o = 1'b1;
          load_pc_o      = 1'b1;
          alumux1_sel_o  = ALUMUX1_PC;
          alumux2_sel_o  = ALUMUX2_U;
          aluop_o        = ALU_ADD;
        end
        BR: begin
          load_pc_o     = 1'b1;
          pcmux_sel_o   = br_en_i ? PCMUX_ALU : PCMUX_PC4;
          alumux1_sel_o = ALUMUX1_PC;
          alumux2_sel_o = ALUMUX2_B;
          aluop_o       = ALU_ADD;
        end
        JAL, JALR: begin
          load_regfile_o   = 1'b1;
          load_pc_o        = 1'b1;
          regfilemux_sel_o = RF_PC4;
          aluop_o          = ALU_ADD;
          pcmux_sel_o      = (state_q == JAL) ? PCMUX_ALU : PCMUX_MOD2;
          alumux1_sel_o    = (state_q == JAL) ? ALUMUX1_PC : ALUMUX1_RS1;
          alumux2_sel_o    = (state_q == JAL) ? ALUMUX2_J : ALUMUX2_I;
        end
        CALC_ADDR: begin
          aluop_o         = ALU_ADD;
          marmux_sel_o    = MARMUX_ALU;
          alumux2_sel_o   = is_store ? ALUMUX2_S : ALUMUX2_I;
          load_mar_o      = !misaligned;
          load_data_out_o = !misaligned && is_store;
        end
        LD1: begin
          marmux_sel_o = MARMUX_ALU;
          load_mdr_o   = 1'b1;
          mem_read_o   = 1'b1;
        end
        LD2: begin
          load_regfile_o = 1'b1;
          load_pc_o      = 1'b1;
          case (funct3_i)
            3'b000:  regfilemux_sel_o = RF_LB;
            3'b001:  regfilemux_sel_o = RF_LH;
            3'b100:  regfilemux_sel_o = RF_LBU;
            3'b101:  regfilemux_sel_o = RF_LHU;
            default: regfilemux_sel_o = RF_LW;
          endcase
        end
        ST1: begin
          mem_write_o       = 1'b1;
          mem_byte_enable_o = st_mask << byte_offset_q;
        end
        ST2: load_pc_o = 1'b1;
        default: ;
      endcase
    end
  end

  assign byte_offset_o = byte_offset_q;
  assign trap_o        = trap_q;
  assign trap_cause_o  = trap_cause_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: one MDU-enabled instance with a 4-cycle memory timeout,
// plus an MDU-disabled twin on the same inputs whose trap outputs are compared.
module tb_mc_control_fsm;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011, OP_REG = 7'b0110011;

  // {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out, mem_read, mem_write, mdu_start, mdu_wb}
  localparam logic [9:0] C_FETCH1   = 10'b0001000000;
  localparam logic [9:0] C_FETCH2   = 10'b0000101000;
  localparam logic [9:0] C_FETCH3   = 10'b0100000000;
  localparam logic [9:0] C_IMM      = 10'b1010000000;
  localparam logic [9:0] C_CALC_LD  = 10'b0001000000;
  localparam logic [9:0] C_CALC_ST  = 10'b0001010000;
  localparam logic [9:0] C_LD1      = 10'b0000101000;
  localparam logic [9:0] C_ST1      = 10'b0000000100;
  localparam logic [9:0] C_ST2      = 10'b1000000000;
  localparam logic [9:0] C_BR       = 10'b1000000000;
  localparam logic [9:0] C_MDU_GO   = 10'b0000000010;
  localparam logic [9:0] C_MDU_DONE = 10'b1010000001;
  localparam logic [9:0] C_MDU_BOTH = 10'b1010000011;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic [6:0] opcode_i, funct7_i;
  logic [2:0] funct3_i;
  logic br_en_i, mem_resp_i, mdu_done_i;
  logic [1:0] addr_lsb_i;

  logic [1:0] pcmux_sel_o, byte_offset_o, trap_cause_o;
  logic alumux1_sel_o, marmux_sel_o, cmpmux_sel_o;
  logic [2:0] alumux2_sel_o, aluop_o, cmpop_o;
  logic [3:0] regfilemux_sel_o, mem_byte_enable_o;
  logic load_pc_o, load_ir_o, load_regfile_o, load_mar_o, load_mdr_o, load_data_out_o;
  logic mem_read_o, mem_write_o, mdu_start_o, mdu_wb_o, trap_o;

  logic [1:0] n_pcmux, n_off, n_cause;
  logic n_am1, n_mar, n_cmpm, n_lpc, n_lir, n_lrf, n_lmar, n_lmdr, n_ldo, n_rd, n_wr, n_go, n_wb, n_trap;
  logic [2:0] n_am2, n_aluop, n_cmpop;
  logic [3:0] n_rfm, n_be;

  logic [9:0] ctl;
  assign ctl = {load_pc_o, load_ir_o, load_regfile_o, load_mar_o, load_mdr_o,
                load_data_out_o, mem_read_o, mem_write_o, mdu_start_o, mdu_wb_o};

  int n_assert = 0;
  int n_fail   = 0;

  mc_control_fsm #(.DATA_WIDTH(32), .MEM_TIMEOUT(4), .EN_MDU(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
    .br_en_i(br_en_i), .addr_lsb_i(addr_lsb_i), .mem_resp_i(mem_resp_i), .mdu_done_i(mdu_done_i),
    .pcmux_sel_o(pcmux_sel_o), .alumux1_sel_o(alumux1_sel_o), .alumux2_sel_o(alumux2_sel_o),
    .regfilemux_sel_o(regfilemux_sel_o), .marmux_sel_o(marmux_sel_o), .cmpmux_sel_o(cmpmux_sel_o),
    .aluop_o(aluop_o), .cmpop_o(cmpop_o), .load_pc_o(load_pc_o), .load_ir_o(load_ir_o),
    .load_regfile_o(load_regfile_o), .load_mar_o(load_mar_o), .load_mdr_o(load_mdr_o),
    .load_data_out_o(load_data_out_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_byte_enable_o(mem_byte_enable_o), .byte_offset_o(byte_offset_o), .mdu_start_o(mdu_start_o),
    .mdu_wb_o(mdu_wb_o), .trap_o(trap_o), .trap_cause_o(trap_cause_o)
  );

  mc_control_fsm #(.DATA_WIDTH(32), .MEM_TIMEOUT(4), .EN_MDU(0)) dut_nm (
    .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
    .br_en_i(br_en_i), .addr_lsb_i(addr_lsb_i), .mem_resp_i(mem_resp_i), .mdu_done_i(mdu_done_i),
    .pcmux_sel_o(n_pcmux), .alumux1_sel_o(n_am1), .alumux2_sel_o(n_am2), .regfilemux_sel_o(n_rfm),
    .marmux_sel_o(n_mar), .cmpmux_sel_o(n_cmpm), .aluop_o(n_aluop), .cmpop_o(n_cmpop),
    .load_pc_o(n_lpc), .load_ir_o(n_lir), .load_regfile_o(n_lrf), .load_mar_o(n_lmar),
    .load_mdr_o(n_lmdr), .load_data_out_o(n_ldo), .mem_read_o(n_rd), .mem_write_o(n_wr),
    .mem_byte_enable_o(n_be), .byte_offset_o(n_off), .mdu_start_o(n_go), .mdu_wb_o(n_wb),
    .trap_o(n_trap), .trap_cause_o(n_cause)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge, outputs are sampled on the falling edge.
  task automatic nxt();
    @(posedge clk_i);
    #1;
    mem_resp_i = 1'b0;
    mdu_done_i = 1'b0;
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode_i = op;
    funct3_i = f3;
    funct7_i = f7;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    chk("rst_ctl", ctl, 0);
    chk("rst_be", mem_byte_enable_o, 4'hF);
    chk("rst_trap", trap_o, 0);
    chk("rst_cause", trap_cause_o, 0);
    chk("rst_off", byte_offset_o, 0);
    chk("rst_nm_trap", n_trap, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("rst_fetch1", ctl, C_FETCH1);
  endtask

  // Starts in FETCH1 (already sampled), ends sampled in DECODE.
  task automatic do_fetch(input int waits);
    chk("f1", ctl, C_FETCH1);
    for (int i = 0; i < waits; i++) begin
      nxt(); @(negedge clk_i);
      chk("f2_wait", ctl, C_FETCH2);
    end
    nxt(); mem_resp_i = 1'b1; @(negedge clk_i);
    chk("f2_resp", ctl, C_FETCH2);
    nxt(); @(negedge clk_i);
    chk("f3", ctl, C_FETCH3);
    nxt(); @(negedge clk_i);
    chk("decode", ctl, 0);
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [1:0] lsb, input logic [3:0] be);
    set_ir(OP_STORE, f3, 7'd0);
    do_fetch(0);
    nxt(); addr_lsb_i = lsb; @(negedge clk_i);
    chk("st_calc", ctl, C_CALC_ST);
    chk("st_alumux2", alumux2_sel_o, 3);
    chk("st_marmux", marmux_sel_o, 1);
    nxt(); @(negedge clk_i);
    chk("st1", ctl, C_ST1);
    chk("st_off", byte_offset_o, lsb);
    chk("st_be", mem_byte_enable_o, be);
    nxt(); @(negedge clk_i);
    chk("st1_hold", ctl, C_ST1);
    nxt(); mem_resp_i = 1'b1; @(negedge clk_i);
    chk("st1_resp", ctl, C_ST1);
    chk("st_be_resp", mem_byte_enable_o, be);
    nxt(); @(negedge clk_i);
    chk("st2", ctl, C_ST2);
    chk("st2_be", mem_byte_enable_o, 4'hF);
    nxt(); @(negedge clk_i);
    chk("st_done", ctl, C_FETCH1);
  endtask

  task automatic do_misaligned(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] lsb,
                               input logic [1:0] cause);
    set_ir(op, f3, 7'd0);
    do_fetch(0);
    nxt(); addr_lsb_i = lsb; @(negedge clk_i);
    chk("mis_calc_nomar", ctl, 0);
    nxt(); @(negedge clk_i);
    chk("mis_trap", trap_o, 1);
    chk("mis_cause", trap_cause_o, cause);
    chk("mis_quiet", ctl, 0);
    chk("mis_off", byte_offset_o, lsb);
    nxt(); nxt(); mem_resp_i = 1'b1; @(negedge clk_i);
    chk("mis_sticky", {trap_o, trap_cause_o}, {1'b1, cause});
    chk("mis_sticky_ctl", ctl, 0);
    do_reset();
  endtask

  initial begin
    rst_ni = 1'b0;
    set_ir(OP_IMM, 3'd0, 7'd0);
    br_en_i = 1'b0; addr_lsb_i = 2'd0; mem_resp_i = 1'b0; mdu_done_i = 1'b0;
    #2;
    chk("init_ctl", ctl, 0);
    chk("init_be", mem_byte_enable_o, 4'hF);
    chk("init_trap", {trap_o, trap_cause_o}, 0);
    chk("init_off", byte_offset_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("init_fetch1", ctl, C_FETCH1);

    // ADDI x1,x0,5 with a 3-cycle fetch
    set_ir(OP_IMM, 3'd0, 7'd0);
    do_fetch(2);
    nxt(); @(negedge clk_i);
    chk("addi_imm", ctl, C_IMM);
    chk("addi_aluop", aluop_o, 0);
    chk("addi_rfmux", regfilemux_sel_o, 0);
    nxt(); @(negedge clk_i);
    chk("addi_back", ctl, C_FETCH1);

    // BEQ taken
    set_ir(OP_BR, 3'd0, 7'd0);
    br_en_i = 1'b1;
    do_fetch(0);
    nxt(); @(negedge clk_i);
    chk("beq_ctl", ctl, C_BR);
    chk("beq_pcmux", pcmux_sel_o, 1);
    chk("beq_alumux2", alumux2_sel_o, 2);
    nxt(); @(negedge clk_i);
    br_en_i = 1'b0;
    chk("beq_back", ctl, C_FETCH1);

    do_store(3'b000, 2'd2, 4'b0100);
    do_store(3'b001, 2'd2, 4'b1100);

    do_misaligned(OP_LOAD, 3'b010, 2'd1, 2'd1);
    do_misaligned(OP_STORE, 3'b001, 2'd1, 2'd2);

    // Unknown opcode
    set_ir(7'b1111111, 3'd0, 7'd0);
    do_fetch(0);
    nxt(); @(negedge clk_i);
    chk("ill_trap", {trap_o, trap_cause_o}, {1'b1, 2'd0});
    chk("ill_ctl", ctl, 0);
    do_reset();

    // Fetch timeout: four read cycles, then TRAP cause 3
    set_ir(OP_IMM, 3'd0, 7'd0);
    chk("tmo_f1", ctl, C_FETCH1);
    for (int i = 0; i < 4; i++) begin
      nxt(); @(negedge clk_i);
      chk("tmo_read", ctl, C_FETCH2);
    end
    nxt(); @(negedge clk_i);
    chk("tmo_ctl", ctl, 0);
    chk("tmo_trap", {trap_o, trap_cause_o}, {1'b1, 2'd3});
    do_reset();

    // Response on the last counted cycle beats the timeout
    do_fetch(3);
    chk("tmo_edge_notrap", trap_o, 0);
    nxt(); @(negedge clk_i);
    chk("tmo_edge_imm", ctl, C_IMM);
    nxt(); @(negedge clk_i);
    chk("tmo_edge_back", ctl, C_FETCH1);

    // MUL with mdu_done on the fifth wait cycle
    set_ir(OP_REG, 3'd0, 7'b0000001);
    do_fetch(0);
    nxt(); @(negedge clk_i);
    chk("mul_start", ctl, C_MDU_GO);
    chk("mul_nomdu_trap", {n_trap, n_cause}, {1'b1, 2'd0});
    for (int i = 0; i < 3; i++) begin
      nxt(); @(negedge clk_i);
      chk("mul_wait", ctl, 0);
    end
    nxt(); mdu_done_i = 1'b1; @(negedge clk_i);
    chk("mul_done", ctl, C_MDU_DONE);
    nxt(); @(negedge clk_i);
    chk("mul_back", ctl, C_FETCH1);
    chk("mul_notrap", trap_o, 0);

    // mdu_done together with mdu_start
    do_fetch(0);
    nxt(); mdu_done_i = 1'b1; @(negedge clk_i);
    chk("mul_fast", ctl, C_MDU_BOTH);
    nxt(); @(negedge clk_i);
    chk("mul_fast_back", ctl, C_FETCH1);

    // Reset in the middle of a load wait
    set_ir(OP_LOAD, 3'b010, 7'd0);
    do_fetch(0);
    nxt(); addr_lsb_i = 2'd0; @(negedge clk_i);
    chk("lw_calc", ctl, C_CALC_LD);
    nxt(); @(negedge clk_i);
    chk("lw_ld1", ctl, C_LD1);
    nxt(); @(negedge clk_i);
    chk("lw_ld1_hold", ctl, C_LD1);
    #1;
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
